disp_scan_ctrl: RTL and testbench
=================================

Name: disp_scan_ctrl

Overview:
- Drives the 4-digit multiplexed seven-segment display for the MM:SS clock.
- Each frame it snapshots the minute and second counts, then converts them to BCD through one shared split_digits instance: minutes first, seconds second.
- It then scans the four digits, one at a time, with active-low anodes.
- Its digit output feeds the existing BCD-to-segment decoder.

Parameters:
- TICK_DIV, 50000, clk cycles each digit slot stays lit (must be ≥2).
- LZ_BLANK, 1, when 1 the minute tens digit is blanked while it is 0.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- min_in  in  6  binary minutes, nominal 0-59
- sec_in  in  6  binary seconds, nominal 0-59
- freeze  in  1  when 1, SNAP keeps the previous snapshot
- an  out  4  anode enables, active-low; an[0] is the seconds-ones digit
- digit  out  4  BCD value of the lit digit
- dp_n  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse at the end of slot 3
- range_err  out  1  set if the snapshot had min>59 or sec>59

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-SCAN):
  - an=4'b1111, digit=0, dp_n=1, frame_done=0, range_err=0.
  - Snapshot and display registers cleared; slot=0, tick counter=0; state=SNAP.
- FSM states: SNAP → CONV_MIN → CONV_SEC → SCAN → SNAP. Each of the first three lasts exactly 1 cycle.
- SNAP:
  - If freeze=0: min_s←min_in, sec_s←sec_in.
  - range_err←(min_in>59)|(sec_in>59), evaluated on the values captured (or held when freeze=1).
- CONV_MIN: split_digits input driven with min_s; disp[3]←d1, disp[2]←d0.
- CONV_SEC: split_digits input driven with sec_s; disp[1]←d1, disp[0]←d0.
- No split_digits output is used outside these two cycles.
- During SNAP, CONV_MIN and CONV_SEC: an=4'b1111 and dp_n=1, so the display is blank for 3 cycles per frame.
- SCAN:
  - slot runs 0..3; each slot lasts exactly TICK_DIV cycles, counted by the tick counter from 0 to TICK_DIV-1.
  - In slot k: an = ~(1<<k), digit = disp[k].
  - dp_n=0 only in slot 2, marking the MM.SS separator.
  - If LZ_BLANK=1 and disp[3]==0, an stays 4'b1111 during slot 3. digit is still driven and the slot length is unchanged.
  - On the last cycle of slot 3: frame_done=1 for exactly that cycle; next state is SNAP with slot=0.
- Frame length: 3 + 4·TICK_DIV cycles. From reset release to first lit digit: 3 cycles.
- Out-of-range inputs (60-63) are still converted; split_digits yields d1=6, d0=0..3. range_err is only informational.
- All outputs are registered; no combinational path from inputs to outputs.
- min_in/sec_in changes outside SNAP have no effect until the next frame, so the display never tears.

Decomposition:
- Shared package `disp_pkg`:
  - state encoding: SNAP=2'd0, CONV_MIN=2'd1, CONV_SEC=2'd2, SCAN=2'd3
  - ANODES_OFF=4'b1111
  - MAX_MINSEC=59
- Sub-modules:
  - Instantiate the existing split_digits, ports in, d1, d0.
  - Add one new sub-module, scan_tick_gen, holding the TICK_DIV counter. It outputs slot_end, asserted on the last cycle of each slot, and is enabled only in SCAN.

Test Plan (TICK_DIV=4, LZ_BLANK=1):
- Reset release, min_in=12, sec_in=34:
  - 3 cycles with an=1111.
  - Then, 4 cycles each: an=1110/digit=4, an=1101/digit=3, an=1011/digit=2 with dp_n=0, an=0111/digit=1.
  - frame_done pulses on cycle 19; total frame length is 19 cycles.
- min_in=5, sec_in=9: slot 3 keeps an=1111; slots 0-2 show 9, 0, 5. Repeat with LZ_BLANK=0: slot 3 shows an=0111, digit=0.
- Change sec_in from 34 to 56 mid-slot 1: the current frame still shows 4 then 3; the next frame shows 6 then 5.
- freeze=1 held across SNAP while min_in changes 12→45: the display keeps 12; after release, the next frame shows 45.
- min_in=63, sec_in=0:
  - range_err=1 from the cycle after SNAP through the next SNAP.
  - Slots 3 and 2 show 6 and 3.
  - range_err clears on the following frame once min_in=10.
- Assert rst asynchronously mid-slot 2: an=1111, dp_n=1 and digit=0 before the next clk edge. After release, the sequence restarts with the 3-cycle blank.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the MM:SS seven-segment scan controller.
package disp_pkg;

  typedef enum logic [1:0] {
    SNAP     = 2'd0,
    CONV_MIN = 2'd1,
    CONV_SEC = 2'd2,
    SCAN     = 2'd3
  } state_e;

  typedef struct packed {
    logic [5:0] min;
    logic [5:0] sec;
  } snap_t;

  localparam logic [3:0] ANODES_OFF = 4'b1111;
  localparam logic [5:0] MAX_MINSEC = 6'd59;

endpackage

// File: rtl/scan_tick_gen.sv
// Per-slot dwell counter; flags the last and second-to-last cycle of a slot.
module scan_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic slot_end_o,
  output logic pre_end_o
);

  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  localparam logic [W-1:0] PRE  = W'(TICK_DIV - 2);

  logic [W-1:0] cnt_q, cnt_d;

  assign slot_end_o = en_i && (cnt_q == LAST);
  assign pre_end_o  = en_i && (cnt_q == PRE);

  // Held at zero outside SCAN so every frame starts slot 0 on a clean count.
  always_comb begin
    cnt_d = '0;
    if (en_i && !slot_end_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/split_digits.sv
// Binary 0..63 to two BCD digits; 60..63 come out as tens=6, ones=0..3.
module split_digits (
  input  logic [5:0] in,
  output logic [3:0] d1,
  output logic [3:0] d0
);

  assign d1 = 4'(in / 6'd10);
  assign d0 = 4'(in % 6'd10);

endmodule

// File: rtl/disp_scan_ctrl.sv
// 4-digit MM:SS display scanner: snapshot, two shared BCD conversions, then
// TICK_DIV cycles per digit. Outputs are registered from next-state values.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] min_in,
  input  logic [5:0] sec_in,
  input  logic       freeze,
  output logic [3:0] an,
  output logic [3:0] digit,
  output logic       dp_n,
  output logic       frame_done,
  output logic       range_err
);

  state_e          state_q, state_d;
  snap_t           snap_q, snap_d;
  logic [3:0][3:0] disp_q, disp_d;
  logic [1:0]      slot_q, slot_d;
  logic [3:0]      an_q, an_d, digit_q, digit_d;
  logic            dp_n_q, dp_n_d, frame_done_q, frame_done_d, range_err_q, range_err_d;
  logic [5:0]      split_in;
  logic [3:0]      d1, d0;
  logic            slot_end, pre_end;

  assign split_in = (state_q == CONV_MIN) ? snap_q.min : snap_q.sec;

  split_digits u_split (.in(split_in), .d1(d1), .d0(d0));

  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk        (clk),
    .rst        (rst),
    .en_i       (state_q == SCAN),
    .slot_end_o (slot_end),
    .pre_end_o  (pre_end)
  );

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    disp_d      = disp_q;
    slot_d      = slot_q;
    range_err_d = range_err_q;
    unique case (state_q)
      SNAP: begin
        if (!freeze) begin
          snap_d.min = min_in;
          snap_d.sec = sec_in;
        end
        range_err_d = (snap_d.min > MAX_MINSEC) || (snap_d.sec > MAX_MINSEC);
        state_d     = CONV_MIN;
      end
      CONV_MIN: begin
        disp_d[3] = d1;
        disp_d[2] = d0;
        state_d   = CONV_SEC;
      end
      CONV_SEC: begin
        disp_d[1] = d1;
        disp_d[0] = d0;
        slot_d    = 2'd0;
        state_d   = SCAN;
      end
      SCAN: begin
        if (slot_end) begin
          if (slot_q == 2'd3) begin
            slot_d  = 2'd0;
            state_d = SNAP;
          end else begin
            slot_d = slot_q + 2'd1;
          end
        end
      end
    endcase

    // Drive the lit digit from the upcoming state so it appears with no extra blank cycle.
    an_d    = ANODES_OFF;
    digit_d = 4'd0;
    dp_n_d  = 1'b1;
    if (state_d == SCAN) begin
      digit_d = disp_d[slot_d];
      an_d    = ~(4'b0001 << slot_d);
      dp_n_d  = (slot_d != 2'd2);
      if (LZ_BLANK && slot_d == 2'd3 && disp_d[3] == 4'd0) an_d = ANODES_OFF;
    end
    frame_done_d = (state_q == SCAN) && (slot_q == 2'd3) && pre_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SNAP;
      snap_q       <= '0;
      disp_q       <= '0;
      slot_q       <= 2'd0;
      an_q         <= ANODES_OFF;
      digit_q      <= 4'd0;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
      range_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      disp_q       <= disp_d;
      slot_q       <= slot_d;
      an_q         <= an_d;
      digit_q      <= digit_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
      range_err_q  <= range_err_d;
    end
  end

  assign an         = an_q;
  assign digit      = digit_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;
  assign range_err  = range_err_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Frame-level scoreboard bench for disp_scan_ctrl with TICK_DIV=4; a second
// instance with leading-zero blanking off shares the same inputs.
module tb_disp_scan_ctrl;

  localparam int TD = 4;
  localparam int FLEN = 3 + 4 * TD;

  typedef struct {
    logic [3:0] d3, d2, d1, d0;
    logic       blank3;
    logic       rerr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] min_in, sec_in;
  logic       freeze;
  logic [3:0] an, digit, an_nz, digit_nz;
  logic       dp_n, frame_done, range_err, dp_n_nz, frame_done_nz, range_err_nz;

  int   n_vec = 0, n_err = 0, pushed = 0, popped = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  disp_scan_ctrl #(.TICK_DIV(TD), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .min_in(min_in), .sec_in(sec_in), .freeze(freeze),
    .an(an), .digit(digit), .dp_n(dp_n), .frame_done(frame_done), .range_err(range_err)
  );

  disp_scan_ctrl #(.TICK_DIV(TD), .LZ_BLANK(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .min_in(min_in), .sec_in(sec_in), .freeze(freeze),
    .an(an_nz), .digit(digit_nz), .dp_n(dp_n_nz), .frame_done(frame_done_nz),
    .range_err(range_err_nz)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] d3, d2, d1, d0, input logic b3, re);
    exp_t e;
    e.d3 = d3; e.d2 = d2; e.d1 = d1; e.d0 = d0; e.blank3 = b3; e.rerr = re;
    return e;
  endfunction

  // Starts just after the edge that opens SNAP; returns len edges later.
  task automatic run_frame(input logic [5:0] m, input logic [5:0] s, input logic frz,
                           input exp_t e, input int mid_at, input logic [5:0] mid_sec,
                           input int len);
    min_in = m; sec_in = s; freeze = frz;
    sb.push_back(e);
    pushed++;
    for (int c = 1; c <= len; c++) begin
      @(posedge clk); #1;
      if (c == mid_at) sec_in = mid_sec;
    end
  endtask

  // Monitor: tracks frame position from reset release, pops one record per frame.
  initial begin
    int         pos;
    logic       have_cur, prev_rerr;
    exp_t       cur;
    logic [3:0] dv [4];
    logic [3:0] an_exp, an_nz_exp;
    logic       dp_exp, rerr_exp;
    int         k;
    pos = 0; have_cur = 1'b0; prev_rerr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pos = 0; have_cur = 1'b0; prev_rerr = 1'b0;
      end else begin
        if (pos == 0) begin
          have_cur = (sb.size() > 0);
          if (have_cur) begin
            cur = sb.pop_front();
            popped++;
          end
        end
        if (have_cur) begin
          if (pos < 3) begin
            chk("blank_an", {4'h0, an}, 8'h0f);
            chk("blank_dp", {7'h0, dp_n}, 8'h01);
          end else begin
            dv[0] = cur.d0; dv[1] = cur.d1; dv[2] = cur.d2; dv[3] = cur.d3;
            k = (pos - 3) / TD;
            an_nz_exp = ~(4'b0001 << k);
            an_exp = (k == 3 && cur.blank3) ? 4'b1111 : an_nz_exp;
            dp_exp = (k == 2) ? 1'b0 : 1'b1;
            chk($sformatf("an_slot%0d", k), {4'h0, an}, {4'h0, an_exp});
            chk($sformatf("digit_slot%0d", k), {4'h0, digit}, {4'h0, dv[k]});
            chk($sformatf("dp_slot%0d", k), {7'h0, dp_n}, {7'h0, dp_exp});
            chk($sformatf("nz_an_slot%0d", k), {4'h0, an_nz}, {4'h0, an_nz_exp});
            chk($sformatf("nz_digit_slot%0d", k), {4'h0, digit_nz}, {4'h0, dv[k]});
          end
          chk($sformatf("frame_done_pos%0d", pos), {7'h0, frame_done}, {7'h0, pos == FLEN - 1});
          rerr_exp = (pos == 0) ? prev_rerr : cur.rerr;
          chk($sformatf("range_err_pos%0d", pos), {7'h0, range_err}, {7'h0, rerr_exp});
          if (pos == FLEN - 1) prev_rerr = cur.rerr;
        end
        pos = (pos == FLEN - 1) ? 0 : pos + 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; min_in = 6'd0; sec_in = 6'd0; freeze = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", {4'h0, an}, 8'h0f);
    chk("rst_digit", {4'h0, digit}, 8'h00);
    chk("rst_dp", {7'h0, dp_n}, 8'h01);
    chk("rst_fd", {7'h0, frame_done}, 8'h00);
    chk("rst_rerr", {7'h0, range_err}, 8'h00);
    rst = 1'b0;

    run_frame(6'd12, 6'd34, 1'b0, mk(1, 2, 3, 4, 0, 0), 0, 6'd0, FLEN);
    run_frame(6'd5,  6'd9,  1'b0, mk(0, 5, 0, 9, 1, 0), 0, 6'd0, FLEN);
    run_frame(6'd12, 6'd34, 1'b0, mk(1, 2, 3, 4, 0, 0), 8, 6'd56, FLEN);
    run_frame(6'd12, 6'd56, 1'b0, mk(1, 2, 5, 6, 0, 0), 0, 6'd0, FLEN);
    run_frame(6'd45, 6'd56, 1'b1, mk(1, 2, 5, 6, 0, 0), 0, 6'd0, FLEN);
    run_frame(6'd63, 6'd56, 1'b1, mk(1, 2, 5, 6, 0, 0), 0, 6'd0, FLEN);
    run_frame(6'd45, 6'd56, 1'b0, mk(4, 5, 5, 6, 0, 0), 0, 6'd0, FLEN);
    run_frame(6'd63, 6'd0,  1'b0, mk(6, 3, 0, 0, 0, 1), 0, 6'd0, FLEN);
    run_frame(6'd10, 6'd0,  1'b0, mk(1, 0, 0, 0, 0, 0), 0, 6'd0, FLEN);
    run_frame(6'd59, 6'd60, 1'b0, mk(5, 9, 6, 0, 0, 1), 0, 6'd0, FLEN);
    run_frame(6'd0,  6'd0,  1'b0, mk(0, 0, 0, 0, 1, 0), 0, 6'd0, FLEN);

    // Asynchronous reset in the middle of slot 2.
    run_frame(6'd12, 6'd34, 1'b0, mk(1, 2, 3, 4, 0, 0), 0, 6'd0, 12);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_an", {4'h0, an}, 8'h0f);
    chk("async_rst_dp", {7'h0, dp_n}, 8'h01);
    chk("async_rst_digit", {4'h0, digit}, 8'h00);
    chk("async_rst_rerr", {7'h0, range_err}, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_frame(6'd12, 6'd34, 1'b0, mk(1, 2, 3, 4, 0, 0), 0, 6'd0, FLEN);

    repeat (2) @(posedge clk);
    chk("frames_checked", popped[7:0], pushed[7:0]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
